imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 106 ++++++++++
 tb/tb_imm_extend_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a registered main/skid output stage; accepted operands appear one cycle later.
// in_ready is registered (skid empty), so out_ready never reaches upstream combinationally.
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        load,
  input  logic [31:0]       data_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              out_ready,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [2:0] MODE_RSVD = 3'd7;

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [TAG_W-1:0]  main_tag;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [TAG_W-1:0]  skid_tag;

  logic [DATA_W-1:0] ext_data;
  logic              accept;
  logic              take;

  always_comb begin
    ext_data = '0;
    case (load)
      3'd0: ext_data = DATA_W'($signed(data_in[15:0]));
      3'd1: ext_data = DATA_W'(data_in[15:0]);
      3'd2: ext_data = DATA_W'(data_in[25:0]);
      3'd3: ext_data = DATA_W'(data_in[10:6]);
      3'd4: ext_data = DATA_W'($signed({data_in[15:0], 16'h0000}));
      3'd5: ext_data = DATA_W'($signed({data_in[15:0], 2'b00}));
      3'd6: ext_data = {pc_in[DATA_W-1:28], data_in[25:0], 2'b00};
      default: ext_data = '0;
    endcase
  end

  assign accept = in_valid && in_ready;
  // A flush drops whatever is presented in the same cycle.
  assign take   = accept && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (take) begin
        main_valid <= 1'b1;
        main_data  <= ext_data;
        main_tag   <= tag_in;
      end
    end else if (out_ready) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end else if (take) begin
        main_data  <= ext_data;
        main_tag   <= tag_in;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (take) begin
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
      skid_tag   <= tag_in;
    end
  end

  // Set wins over clear so a reserved-mode hit is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (take && (load == MODE_RSVD)) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed vectors with hand-computed results.
module tb_imm_extend_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  load = '0;
  logic [31:0] data_in = '0;
  logic [31:0] pc_in = '0;
  logic [4:0]  tag_in = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_ready;
  logic        err;
  logic        err_clr = 1'b0;
  logic [31:0] exp_in = '0;

  logic        dir_rdy = 1'b1;
  logic        rnd_rdy = 1'b1;
  logic        rnd_en = 1'b0;
  assign out_ready = rnd_en ? rnd_rdy : dir_rdy;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_tag;
  logic        w_err;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic m_err = 1'b0;
  exp_t q[$];

  logic [2:0]  t_ld[12];
  logic [31:0] t_d[12];
  logic [31:0] t_pc[12];
  logic [31:0] t_ex[12];

  imm_extend_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .load(load), .data_in(data_in), .pc_in(pc_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready),
    .err(err), .err_clr(err_clr)
  );

  imm_extend_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .load(3'd4), .data_in(32'h0000_8000), .pc_in(64'h0), .tag_in(5'd3),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_tag(w_out_tag), .out_ready(1'b1),
    .err(w_err), .err_clr(1'b0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: queue occupancy predicts in_ready/out_valid; front entry predicts out_data/out_tag.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      chk("err", {63'd0, err}, {63'd0, m_err});
      if (out_valid && q.size() != 0) begin
        chk("out_data", {32'd0, out_data}, {32'd0, q[0].data});
        chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
      end
      if (!rst_n) begin
        q.delete();
        m_err = 1'b0;
      end else if (flush) begin
        q.delete();
        if (err_clr) m_err = 1'b0;
      end else begin
        if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back('{data: exp_in, tag: tag_in});
        if (in_valid && in_ready && load == 3'd7) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] ld, input logic [31:0] d, input logic [31:0] pc,
                         input logic [4:0] tg, input logic [31:0] ex);
    load = ld; data_in = d; pc_in = pc; tag_in = tg; exp_in = ex; in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] ld, input logic [31:0] d, input logic [31:0] pc,
                      input logic [4:0] tg, input logic [31:0] ex);
    present(ld, d, pc, tg, ex);
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      cyc(1);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
    end
  endtask

  initial begin
    t_ld[0]  = 3'd0; t_d[0]  = 32'h0000_8004; t_pc[0]  = 32'h0;         t_ex[0]  = 32'hFFFF_8004;
    t_ld[1]  = 3'd1; t_d[1]  = 32'h0000_8004; t_pc[1]  = 32'h0;         t_ex[1]  = 32'h0000_8004;
    t_ld[2]  = 3'd2; t_d[2]  = 32'h0000_8004; t_pc[2]  = 32'h0;         t_ex[2]  = 32'h0000_8004;
    t_ld[3]  = 3'd3; t_d[3]  = 32'h0000_8004; t_pc[3]  = 32'h0;         t_ex[3]  = 32'h0000_0000;
    t_ld[4]  = 3'd4; t_d[4]  = 32'h0000_8004; t_pc[4]  = 32'h0;         t_ex[4]  = 32'h8004_0000;
    t_ld[5]  = 3'd5; t_d[5]  = 32'h0000_8004; t_pc[5]  = 32'h0;         t_ex[5]  = 32'hFFFE_0010;
    t_ld[6]  = 3'd6; t_d[6]  = 32'h0800_0040; t_pc[6]  = 32'h4000_0010; t_ex[6]  = 32'h4000_0100;
    t_ld[7]  = 3'd3; t_d[7]  = 32'h0000_07C0; t_pc[7]  = 32'h0;         t_ex[7]  = 32'h0000_001F;
    t_ld[8]  = 3'd2; t_d[8]  = 32'hFFFF_FFFF; t_pc[8]  = 32'h0;         t_ex[8]  = 32'h03FF_FFFF;
    t_ld[9]  = 3'd0; t_d[9]  = 32'hFFFF_7FFF; t_pc[9]  = 32'h0;         t_ex[9]  = 32'h0000_7FFF;
    t_ld[10] = 3'd4; t_d[10] = 32'h0000_1234; t_pc[10] = 32'h0;         t_ex[10] = 32'h1234_0000;
    t_ld[11] = 3'd6; t_d[11] = 32'h03FF_FFFF; t_pc[11] = 32'hF000_0000; t_ex[11] = 32'hFFFF_FFFC;

    // Reset with a valid operand presented: it must be ignored.
    present(3'd1, 32'h1111, 32'h0, 5'd30, 32'h1111);
    cyc(1);
    mon_en = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    w_in_valid = 1'b1;
    cyc(1);
    w_in_valid = 1'b0;
    chk("w64_valid", {63'd0, w_out_valid}, 64'd1);
    chk("w64_lui", w_out_data, 64'hFFFF_FFFF_8000_0000);
    chk("w64_tag", {59'd0, w_out_tag}, 64'd3);
    chk("w64_err", {63'd0, w_err}, 64'd0);
    chk("w64_ready", {63'd0, w_in_ready}, 64'd1);

    // Directed sweep, out_ready held high: each result visible one cycle after acceptance.
    dir_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(t_ld[i], t_d[i], t_pc[i], 5'(i), t_ex[i]);
      chk("lat_valid", {63'd0, out_valid}, 64'd1);
      chk("lat_data", {32'd0, out_data}, {32'd0, t_ex[i]});
    end
    drain();

    // Backpressure: tag 1 held on out, tag 2 in skid, tag 3 blocked.
    dir_rdy = 1'b0;
    send(3'd1, 32'h0001, 32'h0, 5'd1, 32'h0001);
    send(3'd1, 32'h0002, 32'h0, 5'd2, 32'h0002);
    present(3'd1, 32'h0003, 32'h0, 5'd3, 32'h0003);
    cyc(3);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_out_tag", {59'd0, out_tag}, 64'd1);
    dir_rdy = 1'b1;
    wait_accept();
    drain();

    // Reserved mode blocked by in_ready=0 must not set err.
    dir_rdy = 1'b0;
    send(3'd0, 32'h0005, 32'h0, 5'd5, 32'h0005);
    send(3'd0, 32'h0006, 32'h0, 5'd6, 32'h0006);
    present(3'd7, 32'hFFFF_FFFF, 32'h0, 5'd7, 32'h0);
    cyc(3);
    chk("rsvd_blocked_err", {63'd0, err}, 64'd0);
    dir_rdy = 1'b1;
    wait_accept();
    chk("rsvd_err_set", {63'd0, err}, 64'd1);
    drain();
    err_clr = 1'b1;
    present(3'd7, 32'h1234_5678, 32'h0, 5'd8, 32'h0);
    wait_accept();
    err_clr = 1'b0;
    chk("rsvd_set_wins", {63'd0, err}, 64'd1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("err_cleared", {63'd0, err}, 64'd0);
    drain();

    // Flush with both registers full and a blocked operand presented.
    dir_rdy = 1'b0;
    send(3'd1, 32'h00AA, 32'h0, 5'd10, 32'h00AA);
    send(3'd1, 32'h00BB, 32'h0, 5'd11, 32'h00BB);
    present(3'd1, 32'h00CC, 32'h0, 5'd9, 32'h00CC);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    // Flush while an acceptable reserved-mode operand is presented: dropped, err untouched.
    send(3'd1, 32'h00DD, 32'h0, 5'd12, 32'h00DD);
    present(3'd7, 32'h0, 32'h0, 5'd13, 32'h0);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush2_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush2_err", {63'd0, err}, 64'd0);
    dir_rdy = 1'b1;
    cyc(3);

    // Reset mid-operation with err set and both registers full.
    dir_rdy = 1'b0;
    send(3'd7, 32'h0, 32'h0, 5'd14, 32'h0);
    send(3'd1, 32'h00EE, 32'h0, 5'd15, 32'h00EE);
    present(3'd1, 32'h00FF, 32'h0, 5'd16, 32'h00FF);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", {32'd0, out_data}, 64'd0);
    chk("mid_rst_err", {63'd0, err}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    dir_rdy = 1'b1;
    send(t_ld[6], t_d[6], t_pc[6], 5'd17, t_ex[6]);
    drain();

    // Random in_valid gaps and out_ready; order and content checked by the scoreboard.
    rnd_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int k = i % 12;
      repeat ($urandom_range(0, 2)) cyc(1);
      send(t_ld[k], t_d[k], t_pc[k], 5'(i), t_ex[k]);
    end
    rnd_en = 1'b0;
    dir_rdy = 1'b1;
    drain();
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
